// File: rtl/pcf8563_target.sv
// pcf8563_target: I2C target emulating the PCF8563 RTC register file.
// Answers pointer-write, data-write and (repeated-start) read transactions at
// DEV_ADDR, backed by an NREG-byte register file.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   en                target enable; 0 releases SDA and holds the FSM idle
//   scl_i, sda_i      bus pad inputs
//   sda_o, sda_t      SDA open-drain drive (value always 0, sda_t=1 releases)
//   host_addr/rdata   combinational host read port into the register file
//   wr_strobe/addr/data  one-cycle notify per byte written from the bus
//   busy              transaction in progress (START to STOP)
module pcf8563_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h51,
    parameter int unsigned NREG     = 16,
    parameter int unsigned FILT     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_o,
    output logic                    sda_t,
    input  logic [$clog2(NREG)-1:0] host_addr,
    output logic [7:0]              host_rdata,
    output logic                    wr_strobe,
    output logic [$clog2(NREG)-1:0] wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy
);

    localparam int unsigned PW  = $clog2(NREG);
    localparam int unsigned FCW = $clog2(FILT + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_ACK   = 3'd2;
    localparam logic [2:0] ST_WPTR  = 3'd3;
    localparam logic [2:0] ST_WDATA = 3'd4;
    localparam logic [2:0] ST_RDATA = 3'd5;
    localparam logic [2:0] ST_MACK  = 3'd6;
    localparam logic [2:0] ST_WAIT  = 3'd7;  // after master NACK, until STOP/START

    // Input conditioning: 2-flop synchronizer, then a level is accepted only
    // after FILT consecutive samples disagree with the current filtered level.
    logic [1:0]     scl_sync_q, sda_sync_q;
    logic           scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;
    logic [FCW-1:0] scl_cnt_q, sda_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FCW'(FILT - 1)) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + FCW'(1);
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FCW'(FILT - 1)) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + FCW'(1);
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q & scl_prev_q;
    // SCL must be high on both samples, so a bus condition never coincides
    // with an SCL edge.
    assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

    logic [2:0]    state_q, state_d, ack_next_q, ack_next_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d, rx_byte;
    logic [PW-1:0] ptr_q, ptr_d, wr_addr_d;
    logic          ack_on_q, ack_on_d, mack_ack_q, mack_ack_d;
    logic          sda_t_q, sda_t_d, wr_strobe_q, wr_strobe_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NREG];

    always_comb begin
        state_d     = state_q;
        ack_next_d  = ack_next_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        ack_on_d    = ack_on_q;
        mack_ack_d  = mack_ack_q;
        sda_t_d     = sda_t_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data_q;
        rx_byte     = {shreg_q[6:0], sda_f_q};
        if (!en) begin
            state_d    = ST_IDLE;
            sda_t_d    = 1'b1;
            ack_on_d   = 1'b0;
            mack_ack_d = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps the pointer.
            state_d    = ST_ADDR;
            bitcnt_d   = 3'd0;
            sda_t_d    = 1'b1;
            ack_on_d   = 1'b0;
            mack_ack_d = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            sda_t_d = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR, ST_WPTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = ST_ACK;
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    ack_next_d = rx_byte[0] ? ST_RDATA : ST_WPTR;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_WPTR) begin
                                ptr_d      = rx_byte[PW-1:0];
                                ack_next_d = ST_WDATA;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_q + PW'(1);
                                ack_next_d  = ST_WDATA;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    // First fall starts the ACK bit, second fall ends it.
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_t_d  = 1'b0;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d = 1'b0;
                            bitcnt_d = 3'd0;
                            state_d  = ack_next_q;
                            if (ack_next_q == ST_RDATA) begin
                                shreg_d = regs_q[ptr_q];
                                sda_t_d = regs_q[ptr_q][7];
                            end else begin
                                sda_t_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 3'd7) begin
                            sda_t_d    = 1'b1;
                            ptr_d      = ptr_q + PW'(1);
                            bitcnt_d   = 3'd0;
                            mack_ack_d = 1'b0;
                            state_d    = ST_MACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_t_d  = shreg_q[6];
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise) begin
                        if (sda_f_q) begin
                            state_d = ST_WAIT;
                        end else begin
                            mack_ack_d = 1'b1;
                        end
                    end else if (scl_fall && mack_ack_q) begin
                        mack_ack_d = 1'b0;
                        shreg_d    = regs_q[ptr_q];
                        sda_t_d    = regs_q[ptr_q][7];
                        bitcnt_d   = 3'd0;
                        state_d    = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ack_next_q  <= ST_WPTR;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= '0;
            ack_on_q    <= 1'b0;
            mack_ack_q  <= 1'b0;
            sda_t_q     <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr     <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            ack_next_q  <= ack_next_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            ack_on_q    <= ack_on_d;
            mack_ack_q  <= mack_ack_d;
            sda_t_q     <= sda_t_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr     <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_strobe_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign sda_o      = 1'b0;
    assign sda_t      = sda_t_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_pcf8563_target.sv
// Bench for pcf8563_target: an I2C master model drives the bus, a byte-level
// register model predicts write notifications and read data.
module tb_pcf8563_target;

    localparam int Q = 12;  // clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n, en, m_scl, m_sda;
    logic       sda_o, sda_t, sda_line;
    logic [3:0] host_addr, wr_addr;
    logic [7:0] host_rdata, wr_data;
    logic       wr_strobe, busy;

    always #5 clk = ~clk;

    assign sda_line = m_sda & (sda_t ? 1'b1 : sda_o);

    pcf8563_target #(
        .DEV_ADDR (7'h51),
        .NREG     (16),
        .FILT     (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .scl_i      (m_scl),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .sda_t      (sda_t),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mdl [16];
    int         mdl_ptr = 0;
    int         wr_q [$];
    logic [7:0] rd_q [$];
    int         low_cnt = 0;
    logic       track = 1'b0;
    logic       scl_d1 = 1'b1;
    logic       sdat_d1 = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for bus writes.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            if (wr_q.size() == 0) begin
                check("wr_strobe_unexpected", 32'(wr_strobe), 0);
            end else begin
                int exp;
                exp = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(exp[11:8]));
                check("wr_data", 32'(wr_data), 32'(exp[7:0]));
            end
        end
    end

    // sda_t may only change while SCL is low.
    always @(negedge clk) begin
        if (rst_n && en && sda_t !== sdat_d1) begin
            check("sda_t_scl_low", 32'(m_scl | scl_d1), 0);
        end
        if (track && !sda_t) low_cnt++;
        scl_d1  <= m_scl;
        sdat_d1 <= sda_t;
    end

    task automatic half_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; half_q();
        m_scl = 1'b1; half_q();
        m_sda = 1'b0; half_q();
        m_scl = 1'b0; half_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; half_q();
        m_scl = 1'b1; half_q();
        m_sda = 1'b1; half_q();
    endtask

    task automatic clk_bit(input logic b, input logic glitch, output logic r);
        m_sda = b; half_q();
        m_scl = 1'b1; half_q();
        if (glitch) begin
            m_sda = ~b;
            @(negedge clk);
            m_sda = b;
        end
        r = sda_line; half_q();
        m_scl = 1'b0; half_q();
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], gmask[i], r);
        clk_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, 1'b0, r);
            d = {d[6:0], r};
        end
        clk_bit(nack, 1'b0, r);
    endtask

    task automatic send(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        write_byte(d, 8'h00, a);
        check(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic set_ptr(input logic [7:0] d);
        send(d, 1'b0, "ack_ptr");
        mdl_ptr = int'(d) % 16;
    endtask

    task automatic model_write(input logic [7:0] d);
        wr_q.push_back((mdl_ptr << 8) | int'(d));
        mdl[mdl_ptr] = d;
        mdl_ptr = (mdl_ptr + 1) % 16;
    endtask

    task automatic send_data(input logic [7:0] d);
        model_write(d);
        send(d, 1'b0, "ack_data");
    endtask

    task automatic recv(input logic nack, input string tag);
        logic [7:0] d;
        rd_q.push_back(mdl[mdl_ptr]);
        mdl_ptr = (mdl_ptr + 1) % 16;
        read_byte(nack, d);
        check(tag, 32'(d), 32'(rd_q.pop_front()));
    endtask

    task automatic host_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
        host_addr = a;
        #1;
        check(tag, 32'(host_rdata), 32'(exp));
    endtask

    initial begin
        logic r;
        logic a;
        int   low_start;
        rst_n = 1'b0; en = 1'b1; m_scl = 1'b1; m_sda = 1'b1; host_addr = 4'd0;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_sda_t", 32'(sda_t), 1);
        check("rst_sda_o", 32'(sda_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_strobe", 32'(wr_strobe), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        for (int i = 0; i < 16; i++) host_check(4'(i), 8'h00, "rst_reg");

        // Write burst
        i2c_start();
        check("busy_start", 32'(busy), 1);
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h02);
        send_data(8'h45);
        send_data(8'h30);
        i2c_stop();
        check("busy_stop_w", 32'(busy), 0);
        host_check(4'd3, 8'h30, "host_reg3");
        host_check(4'd2, 8'h45, "host_reg2");

        // Pointer write, repeated start, two-byte read
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h02);
        i2c_start();
        send(8'hA3, 1'b0, "ack_addr_r");
        recv(1'b0, "rd_byte0");
        recv(1'b1, "rd_byte1");
        check("sda_t_after_nack", 32'(sda_t), 1);
        check("busy_before_stop", 32'(busy), 1);
        i2c_stop();
        check("busy_stop_r", 32'(busy), 0);

        // Address mismatch: never pulls SDA low, never writes
        low_start = low_cnt;
        track = 1'b1;
        i2c_start();
        send(8'hA0, 1'b1, "nack_addr");
        check("busy_mismatch", 32'(busy), 0);
        send(8'h00, 1'b1, "nack_ptr");
        i2c_stop();
        track = 1'b0;
        check("mismatch_sda_low", 32'(low_cnt - low_start), 0);

        // Seed reg[1], then wrap with an out-of-range pointer byte
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h01);
        send_data(8'h77);
        i2c_stop();
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h1F);
        send_data(8'h11);
        send_data(8'h22);
        i2c_stop();
        host_check(4'd15, 8'h11, "wrap_reg15");
        host_check(4'd0, 8'h22, "wrap_reg0");
        i2c_start();
        send(8'hA3, 1'b0, "ack_addr_r");
        recv(1'b1, "rd_wrap_cur");
        i2c_stop();

        // Glitch on idle bus
        m_sda = 1'b0;
        @(negedge clk);
        m_sda = 1'b1;
        repeat (3 * Q) @(negedge clk);
        check("glitch_idle_busy", 32'(busy), 0);

        // Glitches mimicking STOP (bit7) and START (bit5) inside a data byte
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h06);
        model_write(8'h3C);
        write_byte(8'h3C, 8'hA0, a);
        check("glitch_ack", 32'(a), 0);
        check("glitch_busy", 32'(busy), 1);
        i2c_stop();
        host_check(4'd6, 8'h3C, "glitch_reg6");

        // Enable drop after 4 data bits: no partial write
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h06);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, r);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_sda_t", 32'(sda_t), 1);
        @(negedge clk);
        check("en_drop_busy", 32'(busy), 0);
        half_q();
        en = 1'b1;
        i2c_stop();
        host_check(4'd6, mdl[6], "en_drop_reg6");

        // Reset pulse after 4 data bits
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h03);
        clk_bit(1'b0, 1'b0, r);
        clk_bit(1'b1, 1'b0, r);
        clk_bit(1'b0, 1'b0, r);
        clk_bit(1'b1, 1'b0, r);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl_ptr = 0;
        @(negedge clk);
        check("rst_abort_sda_t", 32'(sda_t), 1);
        check("rst_abort_busy", 32'(busy), 0);
        host_check(4'd3, mdl[3], "rst_abort_reg3");
        host_check(4'd2, mdl[2], "rst_abort_reg2");
        i2c_stop();

        // Target works again after the abort
        i2c_start();
        send(8'hA2, 1'b0, "ack_addr_w");
        set_ptr(8'h03);
        send_data(8'h5E);
        i2c_stop();
        host_check(4'd3, 8'h5E, "post_rst_reg3");

        repeat (4) @(negedge clk);
        check("wr_pending", 32'(wr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
